mem_stage: RTL



---
 rtl/mem_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline stage 4 -- data memory access (SW/LW), branch/jump
// resolution and writeback hand-off. LW takes two cycles and raises STALL.
module mem_stage #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VALID_IN,
  input  logic [15:0] PCIN,
  input  logic [15:0] IRIN,
  input  logic [15:0] DATAIN,
  input  logic [15:0] ADDRIN,
  output logic        STALL,
  output logic        WB_EN,
  output logic [3:0]  WB_REG,
  output logic [15:0] WB_DATA,
  output logic        BR_TAKEN,
  output logic [15:0] BR_TARGET,
  output logic [15:0] PCOUT,
  output logic [15:0] IROUT
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLT  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_JUMP = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] ld_addr_q;
  logic [15:0]       ld_pc_q, ld_ir_q;

  logic [3:0]        op_c;
  logic [ADDR_W-1:0] addr_c;
  logic              mem_we_c, ld_capture_c;
  logic              stall_d, wb_en_d, br_taken_d;
  logic [3:0]        wb_reg_d;
  logic [15:0]       wb_data_d, br_target_d, pc_d, ir_d;
  logic              unused_addr_hi;

  assign op_c           = IRIN[15:12];
  assign addr_c         = ADDRIN[ADDR_W-1:0];
  assign unused_addr_hi = ^ADDRIN[15:ADDR_W];

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, memory strobes and next output values
  always_comb begin
    state_d      = state_q;
    mem_we_c     = 1'b0;
    ld_capture_c = 1'b0;
    stall_d      = 1'b0;
    wb_en_d      = 1'b0;
    wb_reg_d     = 4'h0;
    wb_data_d    = 16'h0000;
    br_taken_d   = 1'b0;
    br_target_d  = 16'h0000;
    pc_d         = 16'h0000;
    ir_d         = 16'h0000;
    unique case (state_q)
      IDLE: begin
        if (VALID_IN) begin
          pc_d = PCIN;
          ir_d = IRIN;
          case (op_c)
            OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_ADDI: begin
              wb_en_d   = 1'b1;
              wb_reg_d  = IRIN[11:8];
              wb_data_d = DATAIN;
            end
            OP_SW: mem_we_c = 1'b1;
            OP_BEQ: begin
              br_taken_d  = (DATAIN == 16'hFFFF);
              br_target_d = (DATAIN == 16'hFFFF) ? ADDRIN : 16'h0000;
            end
            OP_JUMP: begin
              br_taken_d  = 1'b1;
              br_target_d = DATAIN;
            end
            OP_LW: begin
              // Nothing retires this cycle; the load reports next cycle
              pc_d         = 16'h0000;
              ir_d         = 16'h0000;
              ld_capture_c = 1'b1;
              stall_d      = 1'b1;
              state_d      = LOAD;
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        wb_en_d   = 1'b1;
        wb_reg_d  = ld_ir_q[11:8];
        wb_data_d = mem[ld_addr_q];
        pc_d      = ld_pc_q;
        ir_d      = ld_ir_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STALL     <= 1'b0;
      WB_EN     <= 1'b0;
      WB_REG    <= 4'h0;
      WB_DATA   <= 16'h0000;
      BR_TAKEN  <= 1'b0;
      BR_TARGET <= 16'h0000;
      PCOUT     <= 16'h0000;
      IROUT     <= 16'h0000;
    end else begin
      STALL     <= stall_d;
      WB_EN     <= wb_en_d;
      WB_REG    <= wb_reg_d;
      WB_DATA   <= wb_data_d;
      BR_TAKEN  <= br_taken_d;
      BR_TARGET <= br_target_d;
      PCOUT     <= pc_d;
      IROUT     <= ir_d;
    end
  end

  // Load context latched at LW acceptance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ld_addr_q <= '0;
      ld_pc_q   <= 16'h0000;
      ld_ir_q   <= 16'h0000;
    end else if (ld_capture_c) begin
      ld_addr_q <= addr_c;
      ld_pc_q   <= PCIN;
      ld_ir_q   <= IRIN;
    end
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (mem_we_c) mem[addr_c] <= DATAIN;
  end

endmodule
